mult_seq: RTL and testbench

MULT_SEQ -- requirements
Module: mult_seq

---
 rtl/mult_seq.sv | 107 ++++++++++
 tb/tb_mult_seq.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mult_seq.sv
// Sequential shift-add unsigned multiplier. It borrows an external zero-latency adder
// for one partial-product addition per cycle, and takes WIDTH iterations per product.
module mult_seq #(
   parameter int unsigned WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   output logic                 ready,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product,
   output logic [WIDTH-1:0]     add_a,
   output logic [WIDTH-1:0]     add_b,
   input  logic [WIDTH-1:0]     add_sum,
   input  logic                 add_cout
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;
   localparam int unsigned PW = 2 * WIDTH;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] acc_hi, acc_hi_next;
   logic [WIDTH-1:0] acc_lo, acc_lo_next;
   logic [WIDTH-1:0] mcand, mcand_next;
   logic [CW-1:0]    count, count_next;
   logic [PW-1:0]    product_next;
   logic             ready_next, busy_next, done_next;
   logic [WIDTH-1:0] add_a_next, add_b_next;

   // Next-state datapath. The adder operands are precomputed from the next state,
   // so the registered add_a/add_b already present this cycle's partial-product addition.
   always_comb begin
      state_next   = state;
      acc_hi_next  = acc_hi;
      acc_lo_next  = acc_lo;
      mcand_next   = mcand;
      count_next   = count;
      product_next = product;

      case (state)
         IDLE: begin
            if (start) begin
               mcand_next  = multiplicand;
               acc_lo_next = multiplier;
               acc_hi_next = '0;
               count_next  = '0;
               state_next  = RUN;
            end
         end
         RUN: begin
            acc_hi_next = {add_cout, add_sum[WIDTH-1:1]};
            acc_lo_next = {add_sum[0], acc_lo[WIDTH-1:1]};
            count_next  = count + CW'(1);
            if (count == CW'(WIDTH - 1)) begin
               product_next = {add_cout, add_sum, acc_lo[WIDTH-1:1]};
               state_next   = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      ready_next = (state_next == IDLE);
      busy_next  = (state_next == RUN);
      done_next  = (state_next == DONE);
      add_a_next = busy_next ? acc_hi_next : '0;
      add_b_next = (busy_next && acc_lo_next[0]) ? mcand_next : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         acc_hi  <= '0;
         acc_lo  <= '0;
         mcand   <= '0;
         count   <= '0;
         product <= '0;
         ready   <= 1'b1;
         busy    <= 1'b0;
         done    <= 1'b0;
         add_a   <= '0;
         add_b   <= '0;
      end else begin
         state   <= state_next;
         acc_hi  <= acc_hi_next;
         acc_lo  <= acc_lo_next;
         mcand   <= mcand_next;
         count   <= count_next;
         product <= product_next;
         ready   <= ready_next;
         busy    <= busy_next;
         done    <= done_next;
         add_a   <= add_a_next;
         add_b   <= add_b_next;
      end
   end

endmodule

// File: tb/tb_mult_seq.sv
// Bench for mult_seq: randomized and directed multiplies against an arithmetic reference,
// with per-cycle checks of the external adder operands and handshake outputs.
module tb_mult_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [31:0] multiplicand, multiplier;
   logic        ready, busy, done;
   logic [63:0] product;
   logic [31:0] add_a, add_b, add_sum;
   logic        add_cout;

   int n_tests = 0;
   int n_fail  = 0;
   logic [63:0] last_prod;

   always #5 clk = ~clk;

   assign {add_cout, add_sum} = 33'(add_a) + 33'(add_b);

   mult_seq #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .multiplicand(multiplicand), .multiplier(multiplier),
      .ready(ready), .busy(busy), .done(done), .product(product),
      .add_a(add_a), .add_b(add_b), .add_sum(add_sum), .add_cout(add_cout)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, 64'(ready), 64'd1);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_done"}, 64'(done), 64'd0);
      check({tag, "_product"}, product, 64'd0);
      check({tag, "_add_a"}, 64'(add_a), 64'd0);
      check({tag, "_add_b"}, 64'(add_b), 64'd0);
   endtask

   // Called on a negedge. Returns the number of negedges waited for ready.
   task automatic do_mult(input logic [31:0] a, input logic [31:0] b, input bit keep_start,
                          input int inject_at, input int reset_at, output int waited);
      logic [63:0] expect_prod;
      logic [63:0] mask;
      logic [31:0] exp_a, exp_b;
      expect_prod = 64'(a) * 64'(b);
      waited = 0;
      while (!ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      check("ready_before_start", 64'(ready), 64'd1);
      multiplicand = a;
      multiplier   = b;
      start        = 1'b1;
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 32; i++) begin
         if (i == reset_at) begin
            rst_n = 1'b0;
            #1;
            check_reset_outputs("mid_run_reset");
            @(negedge clk);
            check("reset_no_done", 64'(done), 64'd0);
            rst_n     = 1'b1;
            start     = 1'b0;
            last_prod = '0;
            return;
         end
         // Shift-add invariant: after i steps, acc_hi holds the top half of a*(b mod 2^i).
         mask  = (i == 0) ? 64'd0 : ((64'd1 << i) - 64'd1);
         exp_a = 32'((64'(a) * (64'(b) & mask)) >> i);
         exp_b = b[i] ? a : 32'd0;
         check("run_busy", 64'(busy), 64'd1);
         check("run_ready_done", {62'd0, ready, done}, 64'd0);
         check("run_product_stable", product, last_prod);
         check("run_add_a", 64'(add_a), 64'(exp_a));
         check("run_add_b", 64'(add_b), 64'(exp_b));
         if (i == 31 && a == 32'hFFFF_FFFF && b == 32'hFFFF_FFFF)
            check("max_final_cout", 64'(add_cout), 64'd1);
         if (i == inject_at) begin
            start        = 1'b1;
            multiplicand = ~a;
            multiplier   = b ^ 32'h5A5A_A5A5;
         end else begin
            start = keep_start;
         end
         @(negedge clk);
      end
      check("done_pulse", {61'd0, ready, busy, done}, 64'd1);
      check("done_product", product, expect_prod);
      check("done_adder_idle", {add_a, add_b}, 64'd0);
      last_prod = expect_prod;
      if (!keep_start) begin
         @(negedge clk);
         check("after_done_ready", {61'd0, ready, busy, done}, 64'd4);
         check("after_done_product", product, expect_prod);
      end
   endtask

   initial begin
      int w;
      logic [31:0] ra, rb;
      rst_n        = 1'b0;
      start        = 1'b0;
      multiplicand = '0;
      multiplier   = '0;
      last_prod    = '0;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_outputs("post_reset_idle");

      do_mult(32'd3, 32'd5, 1'b0, -1, -1, w);
      check("basic_value", last_prod, 64'h0000_0000_0000_000F);
      do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1, -1, w);
      check("max_value", last_prod, 64'hFFFF_FFFE_0000_0001);
      do_mult(32'd0, 32'h1234_5678, 1'b0, -1, -1, w);
      do_mult(32'h1234_5678, 32'd1, 1'b0, -1, -1, w);
      do_mult(32'd1, 32'hFFFF_FFFF, 1'b0, -1, -1, w);

      for (int k = 0; k < 4; k++) begin
         ra = $urandom;
         rb = $urandom;
         do_mult(ra, rb, 1'b0, -1, -1, w);
      end

      ra = $urandom;
      rb = $urandom;
      do_mult(ra, rb, 1'b0, 10, -1, w);

      ra = $urandom;
      rb = $urandom;
      do_mult(ra, rb, 1'b0, -1, 16, w);
      check_reset_outputs("after_abort");
      do_mult(32'd7, 32'd6, 1'b0, -1, -1, w);
      check("after_abort_value", last_prod, 64'd42);

      // Back-to-back with start held: each new accept must follow DONE by exactly one cycle.
      for (int k = 0; k < 3; k++) begin
         ra = $urandom;
         rb = $urandom;
         do_mult(ra, rb, 1'b1, -1, -1, w);
         if (k > 0) check("b2b_wait", 64'(w), 64'd1);
      end
      start = 1'b0;
      @(negedge clk);
      check("b2b_end_idle", {61'd0, ready, busy, done}, 64'd4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
